calc_test_sequencer: RTL and testbench

CALC_TEST_SEQUENCER -- requirements
Module: calc_test_sequencer

---
 rtl/calc_test_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_calc_test_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_test_sequencer.sv
// calc_test_sequencer
// Runs a table of calculator test vectors against a processor under test.
// For each vector it writes the operands, the operator and a cleared result
// word into data memory, pulses the processor reset, lets the processor run
// for RUN_CYCLES cycles, reads the result word back and scores it against
// the expected value.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                one-cycle run request, accepted only when idle
//   vec_we/vec_idx/...   vector-table write port, ignored while busy
//   mem_we/addr/wdata    data-memory write/address bus (registered)
//   mem_rdata            data-memory read data, one cycle after mem_addr
//   cpu_reset            reset to the processor under test
//   busy, done           run in progress / run finished (sticky)
//   pass_cnt, fail_cnt   per-run scores
//   first_fail/fail_seen index of first failing vector and its valid flag
module calc_test_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_VEC     = 8,
  parameter int unsigned RUN_CYCLES  = 100,
  parameter logic [31:0] RESULT_ADDR = 32'h0000_000C,
  localparam int unsigned IW         = $clog2(NUM_VEC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             vec_we,
  input  logic [IW-1:0]    vec_idx,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic [WIDTH-1:0] vec_op,
  input  logic [WIDTH-1:0] vec_exp,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic [IW:0]      pass_cnt,
  output logic [IW:0]      fail_cnt,
  output logic [IW-1:0]    first_fail,
  output logic             fail_seen
);

  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, WR_OP, WR_CLR, CPU_RST, RUN, RD_ADDR, RD_WAIT, CHECK, DONE
  } state_t;

  localparam logic [IW-1:0] IDX_ONE  = 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_VEC - 1);
  localparam logic [IW:0]   CNT_ONE  = 1;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             rst_cnt_q;
  logic [31:0]      run_cnt_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic             cpu_reset_q;
  logic             busy_q;
  logic             done_q;
  logic [IW:0]      pass_cnt_q;
  logic [IW:0]      fail_cnt_q;
  logic [IW-1:0]    first_fail_q;
  logic             fail_seen_q;

  logic [WIDTH-1:0] tbl_a   [NUM_VEC];
  logic [WIDTH-1:0] tbl_b   [NUM_VEC];
  logic [WIDTH-1:0] tbl_op  [NUM_VEC];
  logic [WIDTH-1:0] tbl_exp [NUM_VEC];

  logic             tbl_wr;
  logic [WIDTH-1:0] first_a_d;
  logic [IW-1:0]    idx_d;

  // Vector table: no reset, so contents survive an aborted run.
  assign tbl_wr = vec_we && !busy_q;

  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      tbl_a[vec_idx]   <= vec_a;
      tbl_b[vec_idx]   <= vec_b;
      tbl_op[vec_idx]  <= vec_op;
      tbl_exp[vec_idx] <= vec_exp;
    end
  end

  // Write data for WR_A is registered on the start edge, so a table write to
  // entry 0 in that same cycle is forwarded to make the run see the new entry.
  always_comb begin
    first_a_d = tbl_a[0];
    if (tbl_wr && (vec_idx == '0)) first_a_d = vec_a;
  end

  assign idx_d = idx_q + IDX_ONE;

  // Every output is registered: each transition loads the values the next
  // state presents. Memory bus defaults to idle (zero) every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rst_cnt_q    <= 1'b0;
      run_cnt_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= WR_A;
            idx_q        <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            mem_we_q     <= 1'b1;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= first_a_d;
          end
        end
        WR_A: begin
          state_q     <= WR_B;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= 32'h4;
          mem_wdata_q <= tbl_b[idx_q];
        end
        WR_B: begin
          state_q     <= WR_OP;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= 32'h8;
          mem_wdata_q <= tbl_op[idx_q];
        end
        WR_OP: begin
          state_q     <= WR_CLR;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= RESULT_ADDR;
          mem_wdata_q <= '0;
        end
        WR_CLR: begin
          state_q   <= CPU_RST;
          rst_cnt_q <= 1'b1;
        end
        CPU_RST: begin
          if (rst_cnt_q) begin
            rst_cnt_q <= 1'b0;
          end else begin
            state_q     <= RUN;
            cpu_reset_q <= 1'b0;
            run_cnt_q   <= RUN_CYCLES - 1;
          end
        end
        RUN: begin
          if (run_cnt_q == '0) begin
            state_q    <= RD_ADDR;
            mem_addr_q <= RESULT_ADDR;
          end else begin
            run_cnt_q <= run_cnt_q - 32'd1;
          end
        end
        RD_ADDR: begin
          // Address held through RD_WAIT so the read data stays stable for CHECK.
          state_q    <= RD_WAIT;
          mem_addr_q <= RESULT_ADDR;
        end
        RD_WAIT: state_q <= CHECK;
        CHECK: begin
          if (mem_rdata == tbl_exp[idx_q]) begin
            pass_cnt_q <= pass_cnt_q + CNT_ONE;
          end else begin
            fail_cnt_q <= fail_cnt_q + CNT_ONE;
            if (!fail_seen_q) begin
              first_fail_q <= idx_q;
              fail_seen_q  <= 1'b1;
            end
          end
          cpu_reset_q <= 1'b1;
          if (idx_q == IDX_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q     <= WR_A;
            idx_q       <= idx_d;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= tbl_a[idx_d];
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;
  assign fail_seen  = fail_seen_q;

endmodule

// File: tb/tb_calc_test_sequencer.sv
// Directed bench for calc_test_sequencer with a 4-word data memory and a
// behavioural calculator processor attached.
module tb_calc_test_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned NV = 4;
  localparam int unsigned RC = 5;
  localparam int unsigned PER_VEC = 4 + 2 + RC + 3;

  logic        clk = 1'b0;
  logic        reset, start, vec_we;
  logic [1:0]  vec_idx;
  logic [W-1:0] vec_a, vec_b, vec_op, vec_exp;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [W-1:0] mem_wdata, mem_rdata;
  logic        cpu_reset, busy, done, fail_seen;
  logic [2:0]  pass_cnt, fail_cnt;
  logic [1:0]  first_fail;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [W-1:0] ea [NV];
  logic [W-1:0] eb [NV];
  logic [W-1:0] eop [NV];

  logic        mon_clr = 1'b0;

  always #5 clk = ~clk;

  calc_test_sequencer #(
    .WIDTH(W), .NUM_VEC(NV), .RUN_CYCLES(RC), .RESULT_ADDR(32'h0000_000C)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .vec_we(vec_we), .vec_idx(vec_idx),
    .vec_a(vec_a), .vec_b(vec_b), .vec_op(vec_op), .vec_exp(vec_exp),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .first_fail(first_fail), .fail_seen(fail_seen)
  );

  // Data memory plus a processor that computes once after leaving reset.
  logic [W-1:0] mem [4];
  bit ran = 1'b0;

  function automatic logic [W-1:0] calc(input logic [W-1:0] a, b, op);
    case (op)
      1: calc = a + b;
      2: calc = a - b;
      3: calc = a * b;
      4: calc = (b == 0) ? '0 : a / b;
      default: calc = '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[3:2]] <= mem_wdata;
    if (cpu_reset) ran <= 1'b0;
    else if (!ran) begin
      ran    <= 1'b1;
      mem[3] <= calc(mem[0], mem[1], mem[2]);
    end
    mem_rdata <= mem[mem_addr[3:2]];
  end

  // Bus / cpu_reset monitor, sampled mid-cycle.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int unsigned hi_q[$];
  int unsigned lo_q[$];
  int unsigned hi_c = 0, lo_c = 0, busy_c = 0;

  always @(negedge clk) begin
    if (reset || mon_clr) begin
      wr_addr_q.delete(); wr_data_q.delete(); hi_q.delete(); lo_q.delete();
      hi_c = 0; lo_c = 0; busy_c = 0;
    end else begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end
      if (busy) busy_c++;
      if (!cpu_reset) begin
        if (hi_c > 0) hi_q.push_back(hi_c);
        hi_c = 0;
        lo_c++;
      end else begin
        if (lo_c > 0) lo_q.push_back(lo_c);
        lo_c = 0;
        if (busy) hi_c++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int unsigned i, input logic [W-1:0] a, b, op, e);
    vec_we = 1'b1; vec_idx = i[1:0]; vec_a = a; vec_b = b; vec_op = op; vec_exp = e;
    ea[i] = a; eb[i] = b; eop[i] = op;
    tick();
    vec_we = 1'b0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    chk("done_reached", done, 1);
    repeat (2) tick();
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_cpu_reset"}, cpu_reset, 1);
    chk({p, "_mem_we"}, mem_we, 0);
    chk({p, "_mem_addr"}, mem_addr, 0);
    chk({p, "_mem_wdata"}, mem_wdata, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_pass_cnt"}, pass_cnt, 0);
    chk({p, "_fail_cnt"}, fail_cnt, 0);
    chk({p, "_first_fail"}, first_fail, 0);
    chk({p, "_fail_seen"}, fail_seen, 0);
  endtask

  task automatic chk_counts(input string p, input int unsigned pc, fc, ff, fs);
    chk({p, "_pass_cnt"}, pass_cnt, pc);
    chk({p, "_fail_cnt"}, fail_cnt, fc);
    chk({p, "_first_fail"}, first_fail, ff);
    chk({p, "_fail_seen"}, fail_seen, fs);
  endtask

  task automatic check_log(input string p);
    logic [31:0] ed;
    chk({p, "_wr_count"}, wr_addr_q.size(), 4 * NV);
    if (wr_addr_q.size() == 4 * NV) begin
      for (int v = 0; v < int'(NV); v++) begin
        for (int k = 0; k < 4; k++) begin
          case (k)
            0: ed = ea[v];
            1: ed = eb[v];
            2: ed = eop[v];
            default: ed = '0;
          endcase
          chk($sformatf("%s_wr_addr_v%0d_%0d", p, v, k), wr_addr_q[v*4+k], 4 * k);
          chk($sformatf("%s_wr_data_v%0d_%0d", p, v, k), wr_data_q[v*4+k], ed);
        end
      end
    end
    chk({p, "_hi_count"}, hi_q.size(), NV);
    chk({p, "_lo_count"}, lo_q.size(), NV);
    foreach (hi_q[i]) chk($sformatf("%s_cpu_rst_hi_%0d", p, i), hi_q[i], 6);
    foreach (lo_q[i]) chk($sformatf("%s_cpu_rst_lo_%0d", p, i), lo_q[i], RC + 3);
    chk({p, "_busy_cycles"}, busy_c, NV * PER_VEC);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vec_we = 1'b0; vec_idx = '0;
    vec_a = '0; vec_b = '0; vec_op = '0; vec_exp = '0;
    repeat (3) tick();
    chk_reset("por");
    reset = 1'b0;
    tick();

    load(0, 10, 5, 1, 15);
    load(1, 4, 6, 3, 24);
    load(2, 50, 0, 4, 0);
    load(3, 7, 2, 2, 5);

    // All vectors pass.
    clear_mon();
    pulse_start();
    chk("start_mem_we", mem_we, 1);
    chk("start_mem_wdata", mem_wdata, 10);
    chk("start_busy", busy, 1);
    wait_done();
    chk_counts("run1", 4, 0, 0, 0);
    repeat (3) tick();
    chk("run1_done_sticky", done, 1);
    chk("run1_busy_idle", busy, 0);
    chk("run1_cpu_reset_idle", cpu_reset, 1);
    check_log("run1");

    // Entry 1 expects 25: one failure at index 1; start also clears done.
    load(1, 4, 6, 3, 25);
    clear_mon();
    pulse_start();
    chk("run2_done_cleared", done, 0);
    chk("run2_pass_cleared", pass_cnt, 0);
    wait_done();
    chk_counts("run2", 3, 1, 1, 1);
    load(1, 4, 6, 3, 24);

    // Repeated start during RUN is ignored.
    clear_mon();
    pulse_start();
    chk("run3_fail_cleared", fail_cnt, 0);
    chk("run3_fseen_cleared", fail_seen, 0);
    repeat (8) tick();
    pulse_start();
    chk("run3_restart_ignored_we", mem_we, 0);
    chk("run3_restart_ignored_rst", cpu_reset, 0);
    repeat (10) tick();
    pulse_start();
    wait_done();
    chk_counts("run3", 4, 0, 0, 0);
    check_log("run3");

    // Table write while busy is dropped.
    clear_mon();
    pulse_start();
    repeat (10) tick();
    vec_we = 1'b1; vec_idx = 2'd0; vec_a = 99; vec_b = 99; vec_op = 1; vec_exp = 0;
    tick();
    vec_we = 1'b0;
    wait_done();
    chk_counts("run4", 4, 0, 0, 0);
    clear_mon();
    pulse_start();
    wait_done();
    chk_counts("run4b", 4, 0, 0, 0);
    check_log("run4b");

    // Reset during RUN of vector 2 aborts, then a clean rerun.
    clear_mon();
    pulse_start();
    repeat (35) tick();
    chk("run5_in_run_cpu_reset", cpu_reset, 0);
    chk("run5_in_run_busy", busy, 1);
    chk("run5_in_run_pass", pass_cnt, 2);
    reset = 1'b1;
    tick();
    chk_reset("midrst");
    reset = 1'b0;
    repeat (5) tick();
    chk("midrst_no_writes", wr_addr_q.size(), 0);
    clear_mon();
    pulse_start();
    wait_done();
    chk_counts("run5", 4, 0, 0, 0);
    check_log("run5");

    // Table write coincident with start: the run uses the new entry 0.
    clear_mon();
    vec_we = 1'b1; vec_idx = 2'd0; vec_a = 20; vec_b = 3; vec_op = 2; vec_exp = 17;
    ea[0] = 20; eb[0] = 3; eop[0] = 2;
    start = 1'b1;
    tick();
    start = 1'b0; vec_we = 1'b0;
    chk("run6_first_wdata", mem_wdata, 20);
    wait_done();
    chk_counts("run6", 4, 0, 0, 0);
    check_log("run6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
